// File: rtl/snake_pkg.sv
// Shared constants for the PS/2 key decoder: one-hot output codes, scan codes
// and state types for the frame and sequence FSMs.
package snake_pkg;

    localparam logic [4:0] DIR_NONE  = 5'b00000;
    localparam logic [4:0] DIR_UP    = 5'b00010;
    localparam logic [4:0] DIR_LEFT  = 5'b00100;
    localparam logic [4:0] DIR_DOWN  = 5'b01000;
    localparam logic [4:0] DIR_RIGHT = 5'b10000;

    localparam logic [4:0] NUM_NONE  = 5'b00000;
    localparam logic [4:0] NUM_1     = 5'b00010;
    localparam logic [4:0] NUM_2     = 5'b00100;
    localparam logic [4:0] NUM_3     = 5'b01000;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_3     = 8'h26;

    typedef enum logic {FR_IDLE, FR_RX} frame_state_t;
    typedef enum logic [1:0] {SQ_BASE, SQ_EXT, SQ_BRK, SQ_EXT_BRK} seq_state_t;

    // Extended arrow codes only; DIR_NONE for anything else.
    function automatic logic [4:0] dir_of(input logic [7:0] code);
        case (code)
            SC_UP:    dir_of = DIR_UP;
            SC_LEFT:  dir_of = DIR_LEFT;
            SC_DOWN:  dir_of = DIR_DOWN;
            SC_RIGHT: dir_of = DIR_RIGHT;
            default:  dir_of = DIR_NONE;
        endcase
    endfunction

    function automatic logic [4:0] num_of(input logic [7:0] code);
        case (code)
            SC_1:    num_of = NUM_1;
            SC_2:    num_of = NUM_2;
            SC_3:    num_of = NUM_3;
            default: num_of = NUM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 receiver: synchronisers, ps2_clk glitch filter, 11-bit frame FSM and
// mid-frame timeout. byte_ok / frame_error are combinational single-cycle pulses.
module ps2_frame_rx
    import snake_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_ok,
    output logic [7:0] rx_byte,
    output logic       frame_error
);
    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [1:0]      clk_sync, dat_sync;
    logic [FW-1:0]   filt_cnt;
    logic            filt, fall, fall_dat;
    frame_state_t    state, nxt;
    logic [3:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par;
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt_cnt <= '0;
            filt     <= 1'b1;
            fall     <= 1'b0;
            fall_dat <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            fall     <= 1'b0;
            fall_dat <= dat_sync[1];
            // Level flips on the FILTER_LEN-th consecutive sample at the new level.
            if (clk_sync[1] == filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt     <= clk_sync[1];
                filt_cnt <= '0;
                fall     <= filt;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign to_hit  = (to_cnt == TO_W'(TIMEOUT_CYCLES));
    assign rx_byte = shreg;

    always_comb begin
        nxt         = state;
        byte_ok     = 1'b0;
        frame_error = 1'b0;
        case (state)
            FR_IDLE: begin
                if (fall) begin
                    if (!fall_dat) nxt = FR_RX;
                    else           frame_error = 1'b1;
                end
            end
            FR_RX: begin
                // A fall takes priority over the timeout terminal count.
                if (fall) begin
                    if (bit_cnt == 4'd10) begin
                        nxt = FR_IDLE;
                        if (fall_dat && (^{shreg, par})) byte_ok = 1'b1;
                        else                              frame_error = 1'b1;
                    end
                end else if (to_hit) begin
                    frame_error = 1'b1;
                    nxt         = FR_IDLE;
                end
            end
            default: nxt = FR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FR_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            to_cnt  <= '0;
        end else begin
            state <= nxt;
            if (fall || nxt != FR_RX || state != FR_RX) to_cnt <= '0;
            else if (to_cnt != '1)                     to_cnt <= to_cnt + 1'b1;
            if (fall) begin
                if (state == FR_IDLE) begin
                    bit_cnt <= 4'd1;
                end else begin
                    if (bit_cnt <= 4'd8) shreg <= {fall_dat, shreg[7:1]};
                    if (bit_cnt == 4'd9) par   <= fall_dat;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: make/break/E0 sequence FSM over ps2_frame_rx, held
// direction/number one-hots and event strobes. Optional macro: REPEAT_FILTER_EN.
module ps2_key_decoder
    import snake_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [4:0] direction,
    output logic [4:0] number,
    output logic [7:0] scan_code,
    output logic       key_valid,
    output logic       key_break,
    output logic       frame_error
);
    logic       byte_ok, rx_err;
    logic [7:0] rx_byte;
    seq_state_t seq, seq_nxt;
    logic       mk, bk, ext, mk_go;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .byte_ok    (byte_ok),
        .rx_byte    (rx_byte),
        .frame_error(rx_err)
    );

    always_comb begin
        seq_nxt = seq;
        mk      = 1'b0;
        bk      = 1'b0;
        ext     = 1'b0;
        if (rx_err) begin
            seq_nxt = SQ_BASE;
        end else if (byte_ok) begin
            case (seq)
                SQ_BASE: begin
                    if      (rx_byte == SC_EXT) seq_nxt = SQ_EXT;
                    else if (rx_byte == SC_BRK) seq_nxt = SQ_BRK;
                    else                        mk = 1'b1;
                end
                SQ_EXT: begin
                    if (rx_byte == SC_BRK) begin
                        seq_nxt = SQ_EXT_BRK;
                    end else if (rx_byte != SC_EXT) begin
                        mk      = 1'b1;
                        ext     = 1'b1;
                        seq_nxt = SQ_BASE;
                    end
                end
                SQ_BRK: begin
                    bk      = 1'b1;
                    seq_nxt = SQ_BASE;
                end
                SQ_EXT_BRK: begin
                    bk      = 1'b1;
                    ext     = 1'b1;
                    seq_nxt = SQ_BASE;
                end
                default: seq_nxt = SQ_BASE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) seq <= SQ_BASE;
        else       seq <= seq_nxt;
    end

`ifdef REPEAT_FILTER_EN
    // {ext, code} of the key currently held down; typematic repeats are dropped.
    logic       held_vld;
    logic [8:0] held_key;

    assign mk_go = mk && !(held_vld && held_key == {ext, rx_byte});

    always_ff @(posedge clk) begin
        if (reset) begin
            held_vld <= 1'b0;
            held_key <= '0;
        end else if (mk_go) begin
            held_vld <= 1'b1;
            held_key <= {ext, rx_byte};
        end else if (bk && held_key == {ext, rx_byte}) begin
            held_vld <= 1'b0;
        end
    end
`else
    assign mk_go = mk;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            direction   <= DIR_NONE;
            number      <= NUM_NONE;
            scan_code   <= '0;
            key_valid   <= 1'b0;
            key_break   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            key_valid   <= mk_go;
            key_break   <= bk;
            frame_error <= rx_err;
            if (mk_go) begin
                scan_code <= rx_byte;
                if (ext && dir_of(rx_byte) != DIR_NONE)  direction <= dir_of(rx_byte);
                if (!ext && num_of(rx_byte) != NUM_NONE) number    <= num_of(rx_byte);
            end
            if (bk) scan_code <= rx_byte;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed test-plan items plus
// randomized key transactions checked against a key-level reference model.
module tb_ps2_key_decoder;
    import snake_pkg::*;

    localparam int HALF = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [4:0] direction, number;
    logic [7:0] scan_code;
    logic       key_valid, key_break, frame_error;

    always #10 clk = ~clk;

    ps2_key_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .direction  (direction),
        .number     (number),
        .scan_code  (scan_code),
        .key_valid  (key_valid),
        .key_break  (key_break),
        .frame_error(frame_error)
    );

    int n_cmp = 0, n_err = 0;
    int cnt_v = 0, cnt_b = 0, cnt_e = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (key_valid)   cnt_v++;
            if (key_break)   cnt_b++;
            if (frame_error) cnt_e++;
        end
    end

    // reference model state, at the level of whole key presses
    logic [4:0] m_dir = DIR_NONE, m_num = NUM_NONE;
    logic [7:0] m_sc = 8'h00;
    bit         m_hv = 0;
    logic [8:0] m_hk = 9'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, ".dir"}, 32'(direction), 32'(m_dir));
        chk({tag, ".num"}, 32'(number),    32'(m_num));
        chk({tag, ".sc"},  32'(scan_code), 32'(m_sc));
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 0,
                              input int nbits = 11, input bit glitch = 0);
        logic [10:0] f;
        f = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            if (glitch) begin
                cyc(4); ps2_clk = 1'b0; cyc(3); ps2_clk = 1'b1; cyc(HALF - 7);
            end else begin
                cyc(HALF);
            end
            ps2_clk = 1'b0;
            cyc(HALF);
            ps2_clk = 1'b1;
        end
        cyc(HALF);
    endtask

    task automatic key(input bit ext, input logic [7:0] code, input bit brk, input bit glitch = 0);
        int v0, b0, e0;
        bit exp_v, exp_b, drop;
        v0 = cnt_v; b0 = cnt_b; e0 = cnt_e;
        exp_v = 0; exp_b = 0; drop = 0;
        if (ext) send_frame(SC_EXT, 0, 11, glitch);
        if (brk) send_frame(SC_BRK, 0, 11, glitch);
        send_frame(code, 0, 11, glitch);
        cyc(5);
        if (brk) begin
            exp_b = 1;
            m_sc  = code;
`ifdef REPEAT_FILTER_EN
            if (m_hv && m_hk == {ext, code}) m_hv = 0;
`endif
        end else begin
`ifdef REPEAT_FILTER_EN
            drop = m_hv && m_hk == {ext, code};
`endif
            if (!drop) begin
                exp_v = 1;
                m_sc  = code;
                m_hv  = 1;
                m_hk  = {ext, code};
                if (ext) begin
                    if      (code == 8'h75) m_dir = 5'b00010;
                    else if (code == 8'h6B) m_dir = 5'b00100;
                    else if (code == 8'h72) m_dir = 5'b01000;
                    else if (code == 8'h74) m_dir = 5'b10000;
                end else begin
                    if      (code == 8'h16) m_num = 5'b00010;
                    else if (code == 8'h1E) m_num = 5'b00100;
                    else if (code == 8'h26) m_num = 5'b01000;
                end
            end
        end
        chk("key.valid", 32'(cnt_v - v0), 32'(exp_v));
        chk("key.break", 32'(cnt_b - b0), 32'(exp_b));
        chk("key.err",   32'(cnt_e - e0), 32'd0);
        chk_outs("key");
    endtask

    initial begin
        int v0, e0, r;
        bit ext, brk, gl;
        logic [7:0] code;

        cyc(5);
        chk("rst.valid", 32'(key_valid), 32'd0);
        chk("rst.break", 32'(key_break), 32'd0);
        chk("rst.err",   32'(frame_error), 32'd0);
        chk_outs("rst");
        reset = 1'b0;
        cyc(5);

        key(1, SC_UP, 0);
        key(1, SC_UP, 1);
        key(0, SC_2, 0);

        e0 = cnt_e; v0 = cnt_v;
        send_frame(SC_1, 1);
        cyc(5);
        chk("par.err",   32'(cnt_e - e0), 32'd1);
        chk("par.valid", 32'(cnt_v - v0), 32'd0);
        chk_outs("par");

        e0 = cnt_e;
        send_frame(8'h1C, 0, 6);
        cyc(50020);
        chk("tmo.err", 32'(cnt_e - e0), 32'd1);
        key(1, SC_LEFT, 0);

        // lone fall with data high looks like a bad start bit
        e0 = cnt_e;
        ps2_dat = 1'b1; cyc(HALF); ps2_clk = 1'b0; cyc(HALF); ps2_clk = 1'b1; cyc(HALF + 5);
        chk("start.err", 32'(cnt_e - e0), 32'd1);

        key(1, SC_DOWN, 0, 1);

        v0 = cnt_v;
        key(1, SC_RIGHT, 0);
        key(1, SC_RIGHT, 0);
        key(1, SC_RIGHT, 0);
`ifdef REPEAT_FILTER_EN
        chk("rep.valid3", 32'(cnt_v - v0), 32'd1);
`else
        chk("rep.valid3", 32'(cnt_v - v0), 32'd3);
`endif
        key(1, SC_RIGHT, 1);
        v0 = cnt_v;
        key(1, SC_RIGHT, 0);
        chk("rep.after_brk", 32'(cnt_v - v0), 32'd1);

        // reset mid-frame: no error, everything back to idle values
        e0 = cnt_e;
        send_frame(8'h55, 0, 5);
        reset = 1'b1; cyc(3); reset = 1'b0;
        m_dir = DIR_NONE; m_num = NUM_NONE; m_sc = 8'h00; m_hv = 0;
        cyc(HALF);
        chk("mrst.err", 32'(cnt_e - e0), 32'd0);
        chk_outs("mrst");
        key(0, SC_3, 0);

        for (int i = 0; i < 16; i++) begin
            r   = $urandom_range(0, 7);
            brk = ($urandom_range(0, 3) == 0);
            gl  = ($urandom_range(0, 1) == 1);
            case (r)
                0: begin ext = 1; code = SC_UP;    end
                1: begin ext = 1; code = SC_LEFT;  end
                2: begin ext = 1; code = SC_DOWN;  end
                3: begin ext = 1; code = SC_RIGHT; end
                4: begin ext = 0; code = SC_1;     end
                5: begin ext = 0; code = SC_2;     end
                6: begin ext = 0; code = SC_3;     end
                default: begin
                    ext  = ($urandom_range(0, 1) == 1);
                    code = 8'($urandom_range(0, 255));
                    if (code == SC_EXT || code == SC_BRK) code = 8'h1C;
                end
            endcase
            key(ext, code, brk, gl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
